load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: takes one load/store request per transaction from the RISC-V core and issues word-wide read/write strobes to the data memory.
- Performs RV32I byte/half/word lane selection, sign/zero extension on loads, and read-modify-write for sub-word stores, because the memory stores whole 32-bit words only.
- Sits between the execute stage and the data memory in the multicycle core.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data-memory port for a multicycle RV32I core.
//   Accepts one load/store at a time, issues word-wide read/write strobes,
//   extracts and extends sub-word load data, and performs read-modify-write
//   for SB/SH because the memory only stores whole words.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   req_valid_i / req_ready_o     request handshake (accepted only in IDLE)
//   req_store_i, req_funct3_i     direction and RV32I width/extension code
//   req_addr_i, req_wdata_i       byte address, right-aligned store data
//   resp_valid_o                  one-cycle response pulse
//   resp_rdata_o, resp_err_o      extended load data (0 on store/error), error flag
//   mem_r_en_o, mem_wr_en_o       mutually exclusive memory strobes
//   mem_addr_o, mem_wdata_o       memory word address, full write word
//   mem_rdata_i, mem_ack_i        read word, strobe completion
module load_store_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int WORD_INDEXED = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_r_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e                state_q;
  logic                  store_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_q;    // only the lane bits are needed after accept
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  resp_valid_q, resp_err_q, r_en_q, wr_en_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q, mem_wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  // Request legality, evaluated on the live request in IDLE
  logic acc_legal, acc_misalign, acc_err;
  always_comb begin
    acc_legal    = req_store_i ? (req_funct3_i inside {3'b000, 3'b001, 3'b010})
                               : (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    acc_misalign = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                   (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
    acc_err      = !acc_legal || acc_misalign;
  end

  logic [ADDR_WIDTH-1:0] acc_mem_addr;
  always_comb begin
    if (WORD_INDEXED != 0) acc_mem_addr = {2'b00, req_addr_i[ADDR_WIDTH-1:2]};
    else                   acc_mem_addr = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
  end

  // Lane extraction for loads and lane merge for SB/SH, both off the read word
  logic [DATA_WIDTH-1:0] lane_b, lane_h, load_ext, lane_mask, wdata_sh, merged;
  always_comb begin
    lane_b   = mem_rdata_i >> {addr_q, 3'b000};
    lane_h   = mem_rdata_i >> {addr_q[1], 4'b0000};
    unique case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane_b[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_h[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
    // SH is halfword aligned, so addr_q*8 also places the halfword correctly
    lane_mask = (funct3_q[1:0] == 2'b00) ? (DATA_WIDTH'(8'hFF)    << {addr_q, 3'b000})
                                         : (DATA_WIDTH'(16'hFFFF) << {addr_q, 3'b000});
    wdata_sh  = wdata_q << {addr_q, 3'b000};
    merged    = (mem_rdata_i & ~lane_mask) | (wdata_sh & lane_mask);
  end

  logic timed_out;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      r_en_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (req_valid_i) begin
          store_q  <= req_store_i;
          funct3_q <= req_funct3_i;
          addr_q   <= req_addr_i[1:0];
          wdata_q  <= req_wdata_i;
          cnt_q    <= '0;
          if (acc_err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            mem_addr_q <= acc_mem_addr;
            if (req_store_i && req_funct3_i == 3'b010) begin
              state_q     <= WR;
              wr_en_q     <= 1'b1;
              mem_wdata_q <= req_wdata_i;
            end else begin
              state_q <= RD;
              r_en_q  <= 1'b1;
            end
          end
        end
        RD: begin
          if (mem_ack_i) begin
            r_en_q <= 1'b0;
            cnt_q  <= '0;
            if (store_q) begin
              state_q     <= WR;
              wr_en_q     <= 1'b1;
              mem_wdata_q <= merged;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= load_ext;
            end
          end else if (timed_out) begin
            // an RMW store abandons here, before any write is issued
            r_en_q       <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR: begin
          if (mem_ack_i || timed_out) begin
            wr_en_q      <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !mem_ack_i;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_r_en_o   = r_en_q;
  assign mem_wr_en_o  = wr_en_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_r_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WORD_INDEXED(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_r_en_o(mem_r_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: contents set only by the stimulus; acks after ack_delay
  // wait cycles (negative = never). Statistics are cumulative.
  logic [31:0] mem [64];
  int ack_delay = 0;
  int wait_cnt = 0;
  int n_rd = 0, n_wr = 0, n_strb = 0, n_both = 0, n_unstable = 0;
  logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, prev_addr = '0;
  logic prev_strb = 1'b0, prev_ack = 1'b0, prev_r = 1'b0;

  always @(negedge clk) begin
    if (prev_strb && !prev_ack && (mem_r_en || mem_wr_en) &&
        (mem_addr != prev_addr || mem_r_en != prev_r))
      n_unstable++;
    if (mem_r_en && mem_wr_en) n_both++;
    if (mem_r_en || mem_wr_en) n_strb++;
    if (!rst_n || !(mem_r_en || mem_wr_en)) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
      mem_ack = 1'b1;
      wait_cnt = 0;
      mem_rdata = mem_r_en ? mem[mem_addr[5:0]] : 32'h0;
      if (mem_r_en) begin n_rd++; rd_addr = mem_addr; end
      if (mem_wr_en) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
    end else begin
      mem_ack = 1'b0;
      wait_cnt++;
    end
    prev_strb = mem_r_en || mem_wr_en;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
    prev_r    = mem_r_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: what the transaction should look like, from the ISA rules
  task automatic predict(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int d,
                         output bit err, output logic [31:0] rdata, output logic [31:0] wword,
                         output int lat, output int nrd, output int nwr, output int nstrb);
    bit legal;
    int size, sh;
    logic [31:0] word, v, mask;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    err   = !legal || (a % size) != 0;
    word  = mem[a[7:2]];
    sh    = 8 * int'(a % 4);
    rdata = '0; wword = '0; nrd = 0; nwr = 0;
    if (err) begin lat = 1; nstrb = 0; return; end
    if (d < 0) begin err = 1'b1; lat = TO + 1; nstrb = TO; return; end
    if (!st) begin
      nrd = 1; lat = 2 + d; nstrb = d + 1;
      v = word >> sh;
      if (size == 1) begin
        rdata = v % 256;
        if (f3 == 3'd0 && rdata >= 128) rdata = rdata - 256;
      end else if (size == 2) begin
        rdata = v % 65536;
        if (f3 == 3'd1 && rdata >= 32768) rdata = rdata - 65536;
      end else rdata = word;
    end else if (size < 4) begin
      nrd = 1; nwr = 1; lat = 3 + 2 * d; nstrb = 2 * d + 2;
      mask  = 32'((64'd1 << (8 * size)) - 1) << sh;
      wword = (word & ~mask) | ((wd << sh) & mask);
    end else begin
      nwr = 1; lat = 2 + d; nstrb = d + 1; wword = wd;
    end
  endtask

  task automatic run_txn(input string tag, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int d);
    bit e_err; logic [31:0] e_rd, e_ww; int e_lat, e_nrd, e_nwr, e_ns;
    int rd0, wr0, s0, cyc;
    predict(st, f3, a, wd, d, e_err, e_rd, e_ww, e_lat, e_nrd, e_nwr, e_ns);
    ack_delay = d;
    @(posedge clk); #1;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    rd0 = n_rd; wr0 = n_wr; s0 = n_strb;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 60) begin
      // busy: offer junk requests that must be ignored
      req_valid = 1'($urandom); req_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0;
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(e_lat));
    chk({tag, " err"}, 32'(resp_err), 32'(e_err));
    chk({tag, " rdata"}, resp_rdata, e_rd);
    chk({tag, " reads"}, 32'(n_rd - rd0), 32'(e_nrd));
    chk({tag, " writes"}, 32'(n_wr - wr0), 32'(e_nwr));
    chk({tag, " strobe cycles"}, 32'(n_strb - s0), 32'(e_ns));
    if (e_nrd != 0) chk({tag, " rd addr"}, rd_addr, a >> 2);
    if (e_nwr != 0) begin
      chk({tag, " wr addr"}, wr_addr, a >> 2);
      chk({tag, " wr data"}, wr_data, e_ww);
    end
    @(posedge clk); #1;
    chk({tag, " pulse one cycle"}, 32'(resp_valid), 32'd0);
    chk({tag, " strobes idle"}, 32'({mem_r_en, mem_wr_en}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_resp;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    // reset state
    #2;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst strobes", 32'({mem_r_en, mem_wr_en}), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    #10 rst_n = 1'b1;

    // directed loads
    mem[3] = 32'h00ABCD00;
    run_txn("LB 0D", 1'b0, 3'b000, 32'h0D, 32'h0, 0);
    run_txn("LHU 0E", 1'b0, 3'b101, 32'h0E, 32'h0, 0);
    mem[3] = 32'h8001FFFF;
    run_txn("LH 0C", 1'b0, 3'b001, 32'h0C, 32'h0, 0);
    mem[3] = 32'h80000000;
    run_txn("LBU 0F", 1'b0, 3'b100, 32'h0F, 32'h0, 0);

    // stores
    mem[3] = 32'h00ABCD00;
    run_txn("SB 0D", 1'b1, 3'b000, 32'h0D, 32'h12345677, 0);
    run_txn("SW 10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    run_txn("SH 1A", 1'b1, 3'b001, 32'h1A, 32'hCAFE5AA5, 1);

    // errors: misaligned and illegal funct3
    run_txn("LW 06", 1'b0, 3'b010, 32'h06, 32'h0, 0);
    run_txn("SH 03", 1'b1, 3'b001, 32'h03, 32'h55, 0);
    run_txn("LD f3=3", 1'b0, 3'b011, 32'h08, 32'h0, 0);
    run_txn("ST f3=4", 1'b1, 3'b100, 32'h08, 32'h0, 0);

    // memory wait states and timeouts
    run_txn("LW wait3", 1'b0, 3'b010, 32'h24, 32'h0, 3);
    run_txn("LW timeout", 1'b0, 3'b010, 32'h28, 32'h0, -1);
    run_txn("SB timeout", 1'b1, 3'b000, 32'h29, 32'hAB, -1);

    // reset in WR with ack pending
    ack_delay = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid wr_en before", 32'(mem_wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid wr_en async", 32'(mem_wr_en), 32'd0);
    chk("rstmid resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) saw_resp = 1'b1;
    end
    chk("rstmid no response", 32'(saw_resp), 32'd0);
    chk("rstmid ready", 32'(req_ready), 32'd1);
    run_txn("LW after rst", 1'b0, 3'b010, 32'h30, 32'h0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit st; logic [2:0] f3; logic [31:0] a;
      st = 1'($urandom);
      f3 = 3'($urandom);
      a  = 32'($urandom_range(255, 0));
      if ($urandom_range(3, 0) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
      run_txn($sformatf("rnd%0d", i), st, f3, a, $urandom, $urandom_range(2, 0));
    end

    chk("strobe exclusivity", 32'(n_both), 32'd0);
    chk("strobe/addr stable while waiting", 32'(n_unstable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
